// File: rtl/uart_pkg.sv
// Shared types and constants for the UART IO bridge.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, power-of-two depth, extra pointer MSB for full/empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
            end
        end
    end

endmodule

// File: rtl/uart_io_bridge.sv
// 8N1 UART bridge for the IO unit byte handshakes.
// Define UART_RX_FIFO_EN for a FIFO receive buffer; else a single holding register.
module uart_io_bridge
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT   = 868,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] io_out_data,
    input  logic       io_out_vld,
    output logic       io_out_rdy,
    output logic [7:0] io_in_data,
    output logic       io_in_vld,
    input  logic       io_in_rdy,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    if (CLK_PER_BIT < 4 || RX_FIFO_DEPTH < 2 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("uart_io_bridge: bad CLK_PER_BIT or RX_FIFO_DEPTH");
    end

    uart_state_e   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_txd_q;

    assign io_out_rdy = (tx_state_q == IDLE);
    assign uart_txd   = tx_txd_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_txd_q   <= STOP_BIT;
        end else begin
            unique case (tx_state_q)
                IDLE: if (io_out_vld) begin
                    tx_shift_q <= io_out_data;
                    tx_cnt_q   <= '0;
                    tx_txd_q   <= START_BIT;
                    tx_state_q <= START;
                end
                START: if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_q   <= '0;
                    tx_bit_q   <= '0;
                    tx_txd_q   <= tx_shift_q[0];
                    tx_state_q <= DATA;
                end else begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                DATA: if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_txd_q   <= STOP_BIT;
                        tx_state_q <= STOP;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_txd_q   <= tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                STOP: if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_q   <= '0;
                    tx_state_q <= IDLE;
                end else begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                end
            endcase
        end
    end

    logic [1:0]    sync_q;
    logic          rxs;
    uart_state_e   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          push_q;
    logic [7:0]    push_data_q;
    logic          frame_err_q;

    assign rxs          = sync_q[1];
    assign rx_frame_err = frame_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q      <= 2'b11;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
            push_q <= 1'b0;
            unique case (rx_state_q)
                IDLE: if (rxs == START_BIT) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= START;
                end
                // Mid-bit resample rejects glitches shorter than half a bit.
                START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= (rxs == START_BIT) ? DATA : IDLE;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                DATA: if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rxs, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 1'b1;
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_q <= STOP;
                    end
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                STOP: if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= IDLE;
                    if (rxs == STOP_BIT) begin
                        push_q      <= 1'b1;
                        push_data_q <= rx_shift_q;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            endcase
        end
    end

    logic pop;
    logic buf_full;
    logic overrun_q;

    assign pop        = io_in_vld && io_in_rdy;
    assign rx_overrun = overrun_q;

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    uart_rx_fifo #(
        .DEPTH(RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (push_q),
        .pop  (pop),
        .din  (push_data_q),
        .dout (io_in_data),
        .full (buf_full),
        .empty(fifo_empty)
    );

    assign io_in_vld = !fifo_empty;
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    assign buf_full   = hold_vld_q;
    assign io_in_vld  = hold_vld_q;
    assign io_in_data = hold_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (push_q && (!hold_vld_q || pop)) begin
            hold_q     <= push_data_q;
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q <= 1'b0;
        end else if (push_q && buf_full && !pop) begin
            overrun_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Scoreboard bench for uart_io_bridge at CLK_PER_BIT=16, RX_FIFO_DEPTH=16.
module tb_uart_io_bridge;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] io_out_data;
    logic       io_out_vld;
    logic       io_out_rdy;
    logic [7:0] io_in_data;
    logic       io_in_vld;
    logic       io_in_rdy;
    logic       uart_rxd;
    logic       uart_txd;
    logic       rx_overrun;
    logic       rx_frame_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         tx_mon_en = 1'b0;
    logic [7:0] tx_b;
    int         busy;

    uart_io_bridge #(
        .CLK_PER_BIT  (CPB),
        .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .io_out_data (io_out_data),
        .io_out_vld  (io_out_vld),
        .io_out_rdy  (io_out_rdy),
        .io_in_data  (io_in_data),
        .io_in_vld   (io_in_vld),
        .io_in_rdy   (io_in_rdy),
        .uart_rxd    (uart_rxd),
        .uart_txd    (uart_txd),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(CPB);
        end
        uart_rxd = stop;
        tick(CPB);
        uart_rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rstn && io_in_vld && io_in_rdy) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected none", io_in_data);
            end else begin
                check("rx_byte", {24'd0, io_in_data}, {24'd0, rx_q.pop_front()});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (tx_mon_en && rstn && uart_txd == 1'b0) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            check("tx_start_bit", {31'd0, uart_txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                tx_b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            check("tx_stop_bit", {31'd0, uart_txd}, 32'd1);
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0h expected none", tx_b);
            end else begin
                check("tx_byte", {24'd0, tx_b}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        rstn        = 1'b0;
        io_out_data = '0;
        io_out_vld  = 1'b0;
        io_in_rdy   = 1'b0;
        uart_rxd    = 1'b1;
        tick(3);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_out_rdy", {31'd0, io_out_rdy}, 32'd1);
        check("rst_in_vld", {31'd0, io_in_vld}, 32'd0);
        check("rst_in_data", {24'd0, io_in_data}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        rstn = 1'b1;
        tick(2);

        // Abort a TX frame with an asynchronous reset.
        io_out_data = 8'h00;
        io_out_vld  = 1'b1;
        tick(1);
        io_out_vld = 1'b0;
        tick(40);
        check("midframe_txd", {31'd0, uart_txd}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_txd", {31'd0, uart_txd}, 32'd1);
        check("async_rst_out_rdy", {31'd0, io_out_rdy}, 32'd1);
        check("async_rst_in_vld", {31'd0, io_in_vld}, 32'd0);
        check("async_rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("async_rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        tx_mon_en = 1'b1;

        // TX 0xA5 then a held vld for 0x5A.
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        io_out_data = 8'hA5;
        io_out_vld  = 1'b1;
        tick(1);
        io_out_data = 8'h5A;
        busy = 0;
        while (busy < 400) begin
            @(negedge clk);
            if (io_out_rdy) break;
            busy++;
        end
        check("tx_busy_cycles", busy, 32'd160);
        tick(1);
        io_out_vld = 1'b0;
        check("tx_second_accept", {31'd0, io_out_rdy}, 32'd0);
        tick(170);
        check("tx_q_empty", tx_q.size(), 32'd0);
        check("tx_idle_rdy", {31'd0, io_out_rdy}, 32'd1);

        // RX 0x3C held until a single-cycle pop.
        rx_q.push_back(8'h3C);
        uart_send(8'h3C, 1'b1);
        tick(4);
        check("rx_vld_rise", {31'd0, io_in_vld}, 32'd1);
        check("rx_data_3c", {24'd0, io_in_data}, 32'h3C);
        tick(10);
        check("rx_vld_hold", {31'd0, io_in_vld}, 32'd1);
        check("rx_data_hold", {24'd0, io_in_data}, 32'h3C);
        io_in_rdy = 1'b1;
        tick(1);
        io_in_rdy = 1'b0;
        check("rx_vld_after_pop", {31'd0, io_in_vld}, 32'd0);

        // Short low glitch is ignored.
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(30);
        check("glitch_vld", {31'd0, io_in_vld}, 32'd0);
        check("glitch_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("glitch_overrun", {31'd0, rx_overrun}, 32'd0);

        // Bad stop bit, then a good frame.
        uart_send(8'h55, 1'b0);
        tick(30);
        check("ferr_flag", {31'd0, rx_frame_err}, 32'd1);
        check("ferr_no_push", {31'd0, io_in_vld}, 32'd0);
        check("ferr_overrun", {31'd0, rx_overrun}, 32'd0);
        io_in_rdy = 1'b1;
        rx_q.push_back(8'h12);
        uart_send(8'h12, 1'b1);
        tick(6);
        io_in_rdy = 1'b0;
        check("ferr_next_rx", rx_q.size(), 32'd0);

        // 17 back-to-back bytes with no consumer.
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < DEPTH; i++) rx_q.push_back(8'(i));
`else
        rx_q.push_back(8'h00);
`endif
        for (int i = 0; i <= DEPTH; i++) uart_send(8'(i), 1'b1);
        tick(6);
        check("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        check("ovr_head", {24'd0, io_in_data}, 32'h00);
        check("ovr_vld", {31'd0, io_in_vld}, 32'd1);
        io_in_rdy = 1'b1;
        tick(DEPTH + 4);
        io_in_rdy = 1'b0;
        check("ovr_drained", rx_q.size(), 32'd0);
        check("ovr_empty", {31'd0, io_in_vld}, 32'd0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_io_bridge.md
# uart_io_bridge

Serial front end for the core's IO unit. Converts the IO unit's byte-wide out handshake into an 8N1 UART transmit stream and deserialises the UART receive line into bytes. Received bytes are buffered and offered on the IO unit's byte-wide in handshake. Sits between the core's IO unit and the board UART pins.

## Interface
- CLK_PER_BIT, 868, clock cycles per UART bit (≥ 4); 100 MHz / 115200 baud
- RX_FIFO_DEPTH, 16, receive buffer depth in bytes; power of two, ≥ 2
- clk  in  1  core clock; all logic on its rising edge
- rstn  in  1  reset, asynchronous, active-low
- io_out_data  in  8  byte to transmit
- io_out_vld  in  1  io_out_data valid
- io_out_rdy  out  1  transmitter idle, byte accepted when vld && rdy
- io_in_data  out  8  oldest received byte, valid while io_in_vld
- io_in_vld  out  1  receive buffer non-empty
- io_in_rdy  in  1  consumer takes byte when vld && rdy
- uart_rxd  in  1  serial receive line, asynchronous, idle high
- uart_txd  out  1  serial transmit line, idle high
- rx_overrun  out  1  sticky: a received byte was dropped because the buffer was full
- rx_frame_err  out  1  sticky: a stop bit sampled low

## Operation
- Reset values: uart_txd=1, io_out_rdy=1, io_in_vld=0, io_in_data=0, rx_overrun=0, rx_frame_err=0.
- Reset clears the FIFO, both state machines, and the synchroniser, whose flops reset to 1.
- Reset mid-frame aborts the frame immediately. uart_txd returns to 1 asynchronously.
- Handshakes complete on the clock edge where vld && rdy.
- No output depends combinationally on a same-cycle handshake input.
- TX FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: io_out_rdy=1. On vld && rdy, latch the byte and go to START.
  - START: txd=0.
  - DATA: transmit 8 bits, LSB first.
  - STOP: txd=1.
  - Each state holds for CLK_PER_BIT cycles, then the next state is entered. STOP returns to IDLE.
  - io_out_rdy=0 in every state except IDLE.
- RX path first passes uart_rxd through a 2-flop synchroniser.
- RX FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised low enters START.
  - START: wait CLK_PER_BIT/2 cycles, then resample the line. If the line is high it was a glitch; return to IDLE with no flag. Otherwise go to DATA.
  - DATA: sample every CLK_PER_BIT cycles, 8 times, shifting the bits in LSB first.
  - STOP: sample after CLK_PER_BIT cycles.
    - Sample high: push the byte.
    - Sample low: discard the byte, set rx_frame_err.
    - Either way, return to IDLE. A low line then starts a new frame immediately.
- Counter widths:
  - Baud counter: $clog2(CLK_PER_BIT) bits, counting from 0 to CLK_PER_BIT-1.
  - Bit counter: 3 bits.
  - FIFO pointers: $clog2(RX_FIFO_DEPTH)+1 bits, wrapping naturally.
  - Full: pointer MSBs differ and the remaining bits are equal. Empty: pointers are equal.
- FIFO boundary cases:
  - Push while full with no pop: the byte is dropped, rx_overrun is set, and the contents are unchanged.
  - Push while full with a pop in the same cycle: both occur and no overrun is flagged.
  - Push and pop when empty: the push happens; the pop cannot occur because io_in_vld=0.
  - io_in_data is a combinational read of mem[rd_ptr] and is stable while io_in_vld && !io_in_rdy.

## Timing
- TX:
  - Byte accepted at edge N.
  - uart_txd falls at N+1.
  - Frame occupies cycles N+1 .. N+10·CLK_PER_BIT.
  - io_out_rdy=1 again from cycle N+10·CLK_PER_BIT+1.
- RX:
  - A line falling edge is seen by the FSM 2 cycles later.
  - The stop bit is sampled about 9.5·CLK_PER_BIT cycles after the edge.
  - io_in_vld rises 1 cycle after the push.
- Throughput:
  - One byte per io_in_rdy cycle from the FIFO.
  - Back-to-back RX frames are sustained with no gap.

## Configuration
- UART_RX_FIFO_EN defined: the receive buffer is the RX_FIFO_DEPTH FIFO described above.
- UART_RX_FIFO_EN undefined:
  - The receive buffer is a single holding register with a valid flag; RX_FIFO_DEPTH is ignored.
  - A push while valid and not popped keeps the old byte, drops the new one, and sets rx_overrun.
  - A push and pop in the same cycle loads the new byte.

## Structure
- Package uart_pkg holds:
  - the TX/RX state enum typedef (IDLE, START, DATA, STOP);
  - the START_BIT=0 and STOP_BIT=1 constants;
  - the DATA_BITS=8 constant.
- Sub-module uart_rx_fifo (parameter DEPTH) provides push, pop, full, empty and dout. It is instantiated only under UART_RX_FIFO_EN.
- TX and RX FSMs stay in the top module.

## Test plan
All scenarios use CLK_PER_BIT=16 and RX_FIFO_DEPTH=16.
- Reset: assert rstn=0 mid-TX frame. Required: uart_txd=1 asynchronously, io_out_rdy=1, io_in_vld=0, both flags 0.
- TX 0xA5: the 10 bits are 0,1,0,1,0,0,1,0,1,1 for 16 cycles each, with io_out_rdy low for 160 cycles. A second vld held high is accepted exactly at cycle 161.
- RX 0x3C frame with io_in_rdy=0: io_in_vld rises with io_in_data=0x3C and holds. io_in_rdy=1 for one cycle then pops it, and io_in_vld=0 on the next cycle.
- RX 17 bytes 0x00..0x10 with io_in_rdy=0:
  - UART_RX_FIFO_EN defined: 16 bytes 0x00..0x0F drain in order and rx_overrun=1.
  - UART_RX_FIFO_EN undefined: only 0x00 is held and rx_overrun=1.
- RX frame 0x55 with stop bit 0: no push, rx_frame_err=1. A following valid frame 0x12 is still received.
- 4-cycle low glitch on uart_rxd: no push and no flags set. The RX FSM is back in IDLE before cycle 12 after the glitch.
